// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Opcodes, control enums and the decoded control bundle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_src_e;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'd0,
        ALU_SUB    = 2'd1,
        ALU_FUNCT  = 2'd2,
        ALU_BRANCH = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        XFER_NONE   = 2'd0,
        XFER_BRANCH = 2'd1,
        XFER_JAL    = 2'd2,
        XFER_JALR   = 2'd3
    } ctrl_xfer_e;

    // All-zero value is a harmless bubble: no write, no memory access, no transfer.
    typedef struct packed {
        logic       alu_src;
        wb_src_e    wb_data_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        alu_op_e    alu_op;
        ctrl_xfer_e ctrl_transfer;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_if.sv
// ============================================================================
// Module      : id_ex_stage_if
// Description : ID-side inputs and EX-side outputs of the ID/EX stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface id_ex_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    import riscv_pkg::*;

    logic                  id_valid;
    logic [DATA_W-1:0]     id_pc;
    logic [DATA_W-1:0]     id_rd1;
    logic [DATA_W-1:0]     id_rd2;
    logic [DATA_W-1:0]     id_imm;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [2:0]            id_funct3;
    logic [6:0]            id_funct7;
    ctrl_t                 id_ctrl;
    logic                  ex_flush;
    logic                  ext_stall;

    logic                  ex_valid;
    logic [DATA_W-1:0]     ex_pc;
    logic [DATA_W-1:0]     ex_rd1;
    logic [DATA_W-1:0]     ex_rd2;
    logic [DATA_W-1:0]     ex_imm;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [2:0]            ex_funct3;
    logic [6:0]            ex_funct7;
    ctrl_t                 ex_ctrl;
    logic                  hazard_stall;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
               id_funct3, id_funct7, id_ctrl, ex_flush, ext_stall,
        input  ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_funct3, ex_funct7, ex_ctrl, hazard_stall, stall_count
    );

    modport slave (
        input  id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
               id_funct3, id_funct7, id_ctrl, ex_flush, ext_stall,
        output ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_funct3, ex_funct7, ex_ctrl, hazard_stall, stall_count
    );

endinterface

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use hazard detection for the ID/EX stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_flush,
    output logic                  hazard_stall
);

    logic w_raw_hz;

    // Both source fields are compared regardless of opcode; an occasional
    // spurious stall on instructions without rs2 is cheaper than decoding.
    assign w_raw_hz = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                      ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    // A taken transfer in EX kills the ID instruction, so its hazard is moot.
    assign hazard_stall = w_raw_hz & ~ex_flush;

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use bubble insertion.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);

    typedef struct packed {
        logic                  valid;
        logic [DATA_W-1:0]     pc;
        logic [DATA_W-1:0]     rd1;
        logic [DATA_W-1:0]     rd2;
        logic [DATA_W-1:0]     imm;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
        ctrl_t                 ctrl;
    } ex_bundle_t;

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ex_bundle_t       ex_q, ex_d, w_id_bundle;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             w_hazard_stall;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .id_valid     (bus.id_valid),
        .id_rs1       (bus.id_rs1),
        .id_rs2       (bus.id_rs2),
        .ex_valid     (ex_q.valid),
        .ex_mem_read  (ex_q.ctrl.mem_read),
        .ex_rd        (ex_q.rd),
        .ex_flush     (bus.ex_flush),
        .hazard_stall (w_hazard_stall)
    );

    always_comb begin
        w_id_bundle = '{valid: bus.id_valid, pc: bus.id_pc, rd1: bus.id_rd1,
                        rd2: bus.id_rd2, imm: bus.id_imm, rs1: bus.id_rs1,
                        rs2: bus.id_rs2, rd: bus.id_rd, funct3: bus.id_funct3,
                        funct7: bus.id_funct7, ctrl: bus.id_ctrl};
        ex_d          = ex_q;
        stall_count_d = stall_count_q;
        // External stall freezes everything, including the counter.
        if (!bus.ext_stall) begin
            if (bus.ex_flush) begin
                ex_d = '0;
            end else if (w_hazard_stall) begin
                ex_d = '0;
                if (stall_count_q != '1) begin
                    stall_count_d = stall_count_q + C_CNT_ONE;
                end
            end else begin
                ex_d = w_id_bundle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q          <= '0;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_pc        = ex_q.pc;
    assign bus.ex_rd1       = ex_q.rd1;
    assign bus.ex_rd2       = ex_q.rd2;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_rs1       = ex_q.rs1;
    assign bus.ex_rs2       = ex_q.rs2;
    assign bus.ex_rd        = ex_q.rd;
    assign bus.ex_funct3    = ex_q.funct3;
    assign bus.ex_funct7    = ex_q.funct7;
    assign bus.ex_ctrl      = ex_q.ctrl;
    assign bus.hazard_stall = w_hazard_stall;
    assign bus.stall_count  = stall_count_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Directed and randomized checks of id_ex_stage against a model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;
    import riscv_pkg::*;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Expected contents of the EX slot and the stall counter.
    logic                  m_valid;
    logic [DATA_W-1:0]     m_pc, m_rd1, m_rd2, m_imm;
    logic [REG_ADDR_W-1:0] m_rs1, m_rs2, m_rd;
    logic [2:0]            m_f3;
    logic [6:0]            m_f7;
    ctrl_t                 m_ctrl;
    int                    m_cnt;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_bubble();
        m_valid = 1'b0; m_pc = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_f3 = '0; m_f7 = '0; m_ctrl = '0;
    endtask

    function automatic logic model_hz();
        logic uses;
        uses = (m_rd == bus.id_rs1) || (m_rd == bus.id_rs2);
        return bus.id_valid && m_valid && m_ctrl.mem_read && (m_rd != 0) && uses && !bus.ex_flush;
    endfunction

    task automatic compare_all();
        chk("ex_valid",    64'(bus.ex_valid),    64'(m_valid));
        chk("ex_pc",       64'(bus.ex_pc),       64'(m_pc));
        chk("ex_rd1",      64'(bus.ex_rd1),      64'(m_rd1));
        chk("ex_rd2",      64'(bus.ex_rd2),      64'(m_rd2));
        chk("ex_imm",      64'(bus.ex_imm),      64'(m_imm));
        chk("ex_rs1",      64'(bus.ex_rs1),      64'(m_rs1));
        chk("ex_rs2",      64'(bus.ex_rs2),      64'(m_rs2));
        chk("ex_rd",       64'(bus.ex_rd),       64'(m_rd));
        chk("ex_funct3",   64'(bus.ex_funct3),   64'(m_f3));
        chk("ex_funct7",   64'(bus.ex_funct7),   64'(m_f7));
        chk("ex_ctrl",     {53'b0, bus.ex_ctrl}, {53'b0, m_ctrl});
        chk("stall_count", 64'(bus.stall_count), 64'(m_cnt));
    endtask

    task automatic chk_hz();
        #1;
        chk("hazard_stall", 64'(bus.hazard_stall), 64'(model_hz()));
    endtask

    // One clock: advance the model by the stage's priority rules, then compare.
    task automatic step();
        logic hz;
        hz = model_hz();
        @(posedge clk);
        if (reset) begin
            model_bubble();
            m_cnt = 0;
        end else if (!bus.ext_stall) begin
            if (bus.ex_flush || hz) begin
                model_bubble();
                if (hz && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            end else begin
                m_valid = bus.id_valid; m_pc = bus.id_pc; m_rd1 = bus.id_rd1;
                m_rd2 = bus.id_rd2; m_imm = bus.id_imm; m_rs1 = bus.id_rs1;
                m_rs2 = bus.id_rs2; m_rd = bus.id_rd; m_f3 = bus.id_funct3;
                m_f7 = bus.id_funct7; m_ctrl = bus.id_ctrl;
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic rand_id();
        logic [CTRL_W-1:0] c;
        c = CTRL_W'($urandom);
        bus.id_valid  = ($urandom_range(0, 3) != 0);
        bus.id_pc     = $urandom;
        bus.id_rd1    = $urandom;
        bus.id_rd2    = $urandom;
        bus.id_imm    = $urandom;
        bus.id_rs1    = REG_ADDR_W'($urandom);
        bus.id_rs2    = REG_ADDR_W'($urandom);
        bus.id_rd     = REG_ADDR_W'($urandom_range(0, 7));
        bus.id_funct3 = 3'($urandom);
        bus.id_funct7 = 7'($urandom);
        bus.id_ctrl   = ctrl_t'(c);
    endtask

    task automatic set_id(input logic v, input int rs1, input int rs2, input int rd,
                          input logic mem_rd);
        rand_id();
        bus.id_valid          = v;
        bus.id_rs1            = REG_ADDR_W'(rs1);
        bus.id_rs2            = REG_ADDR_W'(rs2);
        bus.id_rd             = REG_ADDR_W'(rd);
        bus.id_ctrl.mem_read  = mem_rd;
    endtask

    initial begin
        model_bubble();
        m_cnt = 0;
        reset = 1'b1;
        bus.ex_flush  = 1'b0;
        bus.ext_stall = 1'b0;
        rand_id();

        // Reset held two cycles with random ID traffic.
        @(negedge clk);
        step();
        rand_id();
        step();

        // Pass-through.
        reset = 1'b0;
        set_id(1'b1, 1, 1, 5, 1'b0);
        bus.id_ctrl   = '0;
        bus.id_ctrl.reg_write = 1'b1;
        bus.id_pc     = 32'h40;
        chk_hz();
        step();
        chk("pass_pc",    64'(bus.ex_pc),    64'h40);
        chk("pass_rd",    64'(bus.ex_rd),    64'd5);
        chk("pass_valid", 64'(bus.ex_valid), 64'd1);

        // Load-use on rs1 produces exactly one bubble.
        set_id(1'b1, 0, 0, 5, 1'b1);
        chk_hz();
        step();
        set_id(1'b1, 5, 0, 3, 1'b0);
        chk_hz();
        chk("lu_hz", 64'(bus.hazard_stall), 64'd1);
        step();
        chk("lu_bubble_valid", 64'(bus.ex_valid), 64'd0);
        chk("lu_bubble_ctrl",  {53'b0, bus.ex_ctrl}, 64'd0);
        chk("lu_count",        64'(bus.stall_count), 64'd1);
        chk_hz();
        chk("lu_hz_clear", 64'(bus.hazard_stall), 64'd0);
        step();

        // Load to x0 never stalls.
        set_id(1'b1, 0, 0, 0, 1'b1);
        chk_hz();
        step();
        set_id(1'b1, 3, 0, 4, 1'b0);
        chk_hz();
        chk("x0_hz", 64'(bus.hazard_stall), 64'd0);
        step();
        chk("x0_valid", 64'(bus.ex_valid), 64'd1);

        // Flush masks a concurrent hazard and leaves the counter alone.
        set_id(1'b1, 0, 0, 7, 1'b1);
        chk_hz();
        step();
        set_id(1'b1, 7, 0, 2, 1'b0);
        bus.ex_flush = 1'b1;
        chk_hz();
        chk("flush_hz", 64'(bus.hazard_stall), 64'd0);
        step();
        chk("flush_valid", 64'(bus.ex_valid), 64'd0);
        chk("flush_count", 64'(bus.stall_count), 64'd1);
        bus.ex_flush = 1'b0;

        // External stall with flush and hazard pending freezes the stage.
        set_id(1'b1, 0, 0, 9, 1'b1);
        chk_hz();
        step();
        set_id(1'b1, 9, 9, 2, 1'b0);
        bus.ex_flush  = 1'b1;
        bus.ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_hz();
            step();
            chk("stall_rd",    64'(bus.ex_rd),       64'd9);
            chk("stall_valid", 64'(bus.ex_valid),    64'd1);
            chk("stall_count", 64'(bus.stall_count), 64'd1);
        end
        bus.ex_flush  = 1'b0;
        bus.ext_stall = 1'b0;

        // Drive the counter into saturation and confirm it sticks.
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            set_id(1'b1, 0, 0, 9, 1'b1);
            chk_hz();
            step();
            set_id(1'b1, 9, 0, 2, 1'b0);
            chk_hz();
            step();
        end
        chk("sat_count", 64'(bus.stall_count), 64'(CNT_MAX));

        // Randomized traffic biased toward load-use pairs.
        for (int i = 0; i < 3000; i++) begin
            rand_id();
            if ($urandom_range(0, 1) == 0) bus.id_ctrl.mem_read = 1'b1;
            if ($urandom_range(0, 2) == 0) bus.id_rs1 = m_rd;
            if ($urandom_range(0, 3) == 0) bus.id_rs2 = m_rd;
            bus.ex_flush  = ($urandom_range(0, 7) == 0);
            bus.ext_stall = ($urandom_range(0, 7) == 0);
            reset         = ($urandom_range(0, 99) == 0);
            chk_hz();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
